// File: rtl/delay_meas_pkg.sv
// Shared types and defaults for the delay_meas block: FSM states, default
// marker/quiet words and the pass count used when averaging is enabled.
package delay_meas_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        SEND,
        WAIT
    } state_e;

    localparam logic [15:0] DEF_MARKER     = 16'hA5C3;
    localparam logic [15:0] DEF_QUIET_WORD = 16'h0000;
    localparam int          AVG_PASSES     = 4;

endpackage

// File: rtl/delay_meas_cnt.sv
// Loadable up/down counter with a terminal-count compare, used for both the
// flush countdown and the round-trip cycle count.
module delay_meas_cnt #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic         up_i,
    input  logic [W-1:0] tc_val_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = up_i ? (cnt_q + W'(1)) : (cnt_q - W'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == tc_val_i);

endmodule

// File: rtl/delay_meas.sv
// Path latency meter: flushes the path with QUIET_WORD, sends MARKER once and
// counts cycles until it returns on RX_DATA. Define DELAY_MEAS_AVG_EN to average 4 passes.
module delay_meas
    import delay_meas_pkg::*;
#(
    parameter logic [15:0] MARKER       = DEF_MARKER,
    parameter logic [15:0] QUIET_WORD   = DEF_QUIET_WORD,
    parameter int          FLUSH_CYCLES = 64,
    parameter int          MAX_WAIT     = 255,
    parameter int          CNT_W        = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [15:0]      DATA_IN,
    output logic [15:0]      TX_DATA,
    input  logic [15:0]      RX_DATA,
    output logic             BUSY,
    output logic             DONE,
    output logic             TIMEOUT,
    output logic [CNT_W-1:0] DELAY
);

    // The shared counter must hold both the flush length and the wait count.
    localparam int            FW         = $clog2(FLUSH_CYCLES + 1);
    localparam int            CW         = (FW > CNT_W) ? FW : CNT_W;
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(MAX_WAIT);

    state_e           state_q, state_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] delay_q, delay_d;

    logic             cnt_load, cnt_en, cnt_up, cnt_tc;
    logic [CW-1:0]    cnt_load_val, cnt_tc_val, cnt;
    logic             match;

`ifdef DELAY_MEAS_AVG_EN
    localparam int PW = $clog2(AVG_PASSES);
    logic [PW-1:0] pass_q, pass_d;
    logic [CW+1:0] acc_q, acc_d, sum;
`endif

    assign match = (RX_DATA == MARKER);

    delay_meas_cnt #(
        .W(CW)
    ) u_cnt (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .en_i       (cnt_en),
        .up_i       (cnt_up),
        .tc_val_i   (cnt_tc_val),
        .cnt_o      (cnt),
        .tc_o       (cnt_tc)
    );

    always_comb begin
        state_d      = state_q;
        done_d       = done_q;
        timeout_d    = timeout_q;
        delay_d      = delay_q;
        TX_DATA      = DATA_IN;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        cnt_up       = 1'b0;
        cnt_tc_val   = '0;
`ifdef DELAY_MEAS_AVG_EN
        pass_d       = pass_q;
        acc_d        = acc_q;
        sum          = acc_q + (CW+2)'(cnt);
`endif
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    state_d      = FLUSH;
                    done_d       = 1'b0;
                    timeout_d    = 1'b0;
                    delay_d      = '0;
                    cnt_load     = 1'b1;
                    cnt_load_val = FLUSH_LOAD;
`ifdef DELAY_MEAS_AVG_EN
                    pass_d       = '0;
                    acc_d        = '0;
`endif
                end
            end
            FLUSH: begin
                TX_DATA = QUIET_WORD;
                if (cnt_tc) begin
                    state_d  = SEND;
                    cnt_load = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            // SEND is cycle 0 of the count, so both states share the match logic.
            SEND, WAIT: begin
                TX_DATA    = (state_q == SEND) ? MARKER : QUIET_WORD;
                cnt_tc_val = WAIT_LAST;
                if (match) begin
`ifdef DELAY_MEAS_AVG_EN
                    if (pass_q == PW'(AVG_PASSES - 1)) begin
                        state_d  = IDLE;
                        done_d   = 1'b1;
                        delay_d  = sum[CNT_W+1:2];
                        cnt_load = 1'b1;
                    end else begin
                        pass_d       = pass_q + PW'(1);
                        acc_d        = sum;
                        state_d      = FLUSH;
                        cnt_load     = 1'b1;
                        cnt_load_val = FLUSH_LOAD;
                    end
`else
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    delay_d  = cnt[CNT_W-1:0];
                    cnt_load = 1'b1;
`endif
                end else if (cnt_tc) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                    delay_d   = '1;
                    cnt_load  = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_en  = 1'b1;
                    cnt_up  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            delay_q   <= '0;
`ifdef DELAY_MEAS_AVG_EN
            pass_q    <= '0;
            acc_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            delay_q   <= delay_d;
`ifdef DELAY_MEAS_AVG_EN
            pass_q    <= pass_d;
            acc_q     <= acc_d;
`endif
        end
    end

    assign BUSY    = (state_q != IDLE);
    assign DONE    = done_q;
    assign TIMEOUT = timeout_q;
    assign DELAY   = delay_q;

endmodule

// File: tb/tb_delay_meas.sv
// Bench for delay_meas: a programmable delay line stands in for the path under
// test; expected results come from a per-pass arithmetic model.
module tb_delay_meas;

    localparam logic [15:0] MK    = 16'hA5C3;
    localparam int          FLUSH = 64;
    localparam int          MAXW  = 255;
    localparam int          LINE  = 300;
`ifdef DELAY_MEAS_AVG_EN
    localparam int          PASSES = 4;
`else
    localparam int          PASSES = 1;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [15:0] DATA_IN = 16'h0000;
    logic [15:0] TX_DATA, RX_DATA;
    logic        BUSY, DONE, TIMEOUT;
    logic [7:0]  DELAY;

    int n_chk, n_ok;

    logic [15:0] line [LINE];
    logic        path_clr = 1'b0;
    int          dvec [4];
    int          marker_cnt;
    int          cur_d;

    always #5 CLK = ~CLK;

    delay_meas dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .DATA_IN (DATA_IN),
        .TX_DATA (TX_DATA),
        .RX_DATA (RX_DATA),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .TIMEOUT (TIMEOUT),
        .DELAY   (DELAY)
    );

    // Path under test: a register delay line whose tap is chosen per pass
    // (negative tap = broken path, output stuck at zero).
    always @(posedge CLK) begin
        if (path_clr) begin
            for (int i = 0; i < LINE; i++) line[i] <= 16'h0000;
            marker_cnt <= 0;
        end else begin
            line[0] <= TX_DATA;
            for (int i = 1; i < LINE; i++) line[i] <= line[i-1];
            if (TX_DATA == MK) marker_cnt <= marker_cnt + 1;
        end
    end

    always_comb begin
        cur_d = dvec[(marker_cnt == 0) ? 0 : ((marker_cnt > 4) ? 3 : marker_cnt - 1)];
        if (cur_d < 0)       RX_DATA = 16'h0000;
        else if (cur_d == 0) RX_DATA = TX_DATA;
        else                 RX_DATA = line[cur_d-1];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    function automatic logic [15:0] rnd_word();
        logic [15:0] w;
        do w = 16'($urandom); while (w == MK);
        return w;
    endfunction

    task automatic set_d(input int d);
        for (int i = 0; i < 4; i++) dvec[i] = d;
    endtask

    // Reference: each pass costs FLUSH + 1 (send) + its latency; a pass whose
    // marker never returns within MAXW ends everything with a timeout.
    task automatic model(output logic e_done, output logic e_to,
                         output logic [7:0] e_delay, output int e_busy);
        int sum;
        sum    = 0;
        e_busy = 0;
        e_to   = 1'b0;
        for (int p = 0; p < PASSES; p++) begin
            if (dvec[p] < 0 || dvec[p] > MAXW) begin
                e_busy += FLUSH + 1 + MAXW;
                e_to = 1'b1;
                break;
            end
            e_busy += FLUSH + 1 + dvec[p];
            sum    += dvec[p];
        end
        e_done  = !e_to;
        e_delay = e_to ? 8'hFF : 8'(sum / PASSES);
    endtask

    task automatic run(input string tag, input int again_at, input bit mk_in_idle);
        logic       e_done, e_to;
        logic [7:0] e_delay;
        int         e_busy, n, first;
        model(e_done, e_to, e_delay, e_busy);
        @(posedge CLK); #1;
        path_clr = 1'b1;
        DATA_IN  = rnd_word();
        @(posedge CLK); #1;
        path_clr = 1'b0;
        DATA_IN  = mk_in_idle ? MK : rnd_word();
        START    = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        n     = 0;
        first = -1;
        while (BUSY && n < 4000) begin
            if (TX_DATA == MK && first < 0) first = n;
            START   = (n == again_at);
            DATA_IN = rnd_word();
            @(posedge CLK); #1;
            n++;
        end
        START = 1'b0;
        chk({tag, ".busy_cycles"}, n, e_busy);
        chk({tag, ".marker_cycle"}, first, FLUSH);
        chk({tag, ".done"}, DONE, e_done);
        chk({tag, ".timeout"}, TIMEOUT, e_to);
        chk({tag, ".delay"}, DELAY, e_delay);
        repeat (3) begin
            @(posedge CLK); #1;
            DATA_IN = rnd_word();
        end
        #1;
        chk({tag, ".hold_busy"}, BUSY, 1'b0);
        chk({tag, ".hold_done"}, DONE, e_done);
        chk({tag, ".hold_delay"}, DELAY, e_delay);
        chk({tag, ".idle_tx"}, TX_DATA, DATA_IN);
    endtask

    initial begin
        n_chk = 0;
        n_ok  = 0;
        set_d(0);
        DATA_IN = 16'h1234;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst.busy", BUSY, 1'b0);
        chk("rst.done", DONE, 1'b0);
        chk("rst.timeout", TIMEOUT, 1'b0);
        chk("rst.delay", DELAY, 8'd0);
        chk("rst.tx", TX_DATA, 16'h1234);
        RST = 1'b0;

        set_d(48);  run("d48", -1, 1'b0);
        set_d(0);   run("d0", -1, 1'b0);
        set_d(-1);  run("stuck", -1, 1'b0);
        set_d(10);  run("restart_ignored", 68, 1'b0);
        set_d(MAXW);     run("d_maxwait", -1, 1'b0);
        set_d(MAXW + 1); run("d_over", -1, 1'b0);
        set_d(20);  run("flush_marker", -1, 1'b1);

        // Reset in the middle of WAIT.
        set_d(10);
        @(posedge CLK); #1 path_clr = 1'b1;
        @(posedge CLK); #1 path_clr = 1'b0; START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        repeat (70) @(posedge CLK);
        #1;
        chk("midrst.busy_before", BUSY, 1'b1);
        DATA_IN = 16'h5A5A;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("midrst.busy", BUSY, 1'b0);
        chk("midrst.done", DONE, 1'b0);
        chk("midrst.timeout", TIMEOUT, 1'b0);
        chk("midrst.delay", DELAY, 8'd0);
        chk("midrst.tx", TX_DATA, 16'h5A5A);
        run("after_rst", -1, 1'b0);

        // START coincident with RST must not start a run.
        RST = 1'b1;
        START = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        START = 1'b0;
        chk("rst_start.busy0", BUSY, 1'b0);
        @(posedge CLK); #1;
        chk("rst_start.busy1", BUSY, 1'b0);

        for (int k = 0; k < 6; k++) begin
            set_d(int'($urandom_range(0, 70)));
            run($sformatf("rand%0d", k), -1, 1'b0);
        end

`ifdef DELAY_MEAS_AVG_EN
        dvec[0] = 10; dvec[1] = 11; dvec[2] = 12; dvec[3] = 14;
        run("avg_trunc", -1, 1'b0);
        dvec[0] = 10; dvec[1] = 10; dvec[2] = -1; dvec[3] = 10;
        run("avg_break3", -1, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
